// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port byte-lane RAM between instruction fetch and load/store.
// Data wins contention unless fetch has been refused STARVE_MAX cycles in a row.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int STARVE_MAX = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [31:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [3:0]            d_be,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [31:0]           d_rdata,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [3:0]            mem_wren,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic [3:0]            starve_cnt,
   output logic [1:0]            resp_state
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RESP_IF = 2'd1;
   localparam logic [1:0] ST_RESP_D  = 2'd2;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [1:0]            state_q, state_d;
   logic [3:0]            starve_q, starve_d;
   logic [ADDR_WIDTH-3:0] last_addr_q;
   logic                  unused_low_bits;

   assign unused_low_bits = ^{if_addr[1:0], d_addr[1:0]};

   // Handshake: a requester raises req with stable fields and holds them until the
   // cycle its gnt is high; that cycle is the transfer. Nothing is queued here.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!reset) begin
         if (if_req && (!d_req || starve_q >= STARVE_LIM))
            if_gnt = 1'b1;
         else if (d_req)
            d_gnt = 1'b1;
      end
   end

   always_comb begin
      if (if_gnt)
         mem_addr = if_addr[ADDR_WIDTH-1:2];
      else if (d_gnt)
         mem_addr = d_addr[ADDR_WIDTH-1:2];
      else
         mem_addr = last_addr_q;
   end

   assign mem_wren  = (d_gnt && d_we) ? d_be : 4'b0000;
   assign mem_wdata = d_wdata;

   always_comb begin
      state_d = ST_IDLE;
      if (if_gnt)
         state_d = ST_RESP_IF;
      else if (d_gnt && !d_we)
         state_d = ST_RESP_D;
   end

   always_comb begin
      starve_d = 4'd0;
      if (if_req && !if_gnt)
         starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         starve_q    <= 4'd0;
         last_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         if (if_gnt || d_gnt)
            last_addr_q <= mem_addr;
      end
   end

   // The RAM has a fixed one-cycle read latency, so data passes straight through.
   assign if_rvalid  = (state_q == ST_RESP_IF);
   assign d_rvalid   = (state_q == ST_RESP_D);
   assign if_rdata   = mem_rdata;
   assign d_rdata    = mem_rdata;
   assign starve_cnt = starve_q;
   assign resp_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, hand sequences and a randomized run
// against a transaction-level model with its own golden memory.
module tb_mem_port_arbiter;

   localparam int AW = 15;
   localparam int SMAX = 3;
   localparam int NWORDS = 1 << (AW - 2);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [31:0]   if_rdata;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [3:0]    d_be = 4'h0;
   logic [AW-1:0] d_addr = '0;
   logic [31:0]   d_wdata = '0;
   logic          d_gnt, d_rvalid;
   logic [31:0]   d_rdata;
   logic [AW-3:0] mem_addr;
   logic [3:0]    mem_wren;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;
   logic [3:0]    starve_cnt;
   logic [1:0]    resp_state;

   int tests = 0;
   int fails = 0;

   logic [31:0] ram  [NWORDS];
   logic [31:0] gold [NWORDS];
   logic [33:0] exp_q[$];

   mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .starve_cnt(starve_cnt), .resp_state(resp_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Byte-lane single-port RAM, read-first, one-cycle latency.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (mem_wren[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int w, input logic [31:0] v);
      ram[w]  = v;
      gold[w] = v;
   endtask

   task automatic drive_if(input logic req, input logic [AW-1:0] a);
      if_req  = req;
      if_addr = a;
   endtask

   task automatic drive_d(input logic req, input logic we, input logic [3:0] be,
                          input logic [AW-1:0] a, input logic [31:0] wd);
      d_req   = req;
      d_we    = we;
      d_be    = be;
      d_addr  = a;
      d_wdata = wd;
   endtask

   typedef struct {
      logic       if_req;
      logic       d_req;
      logic       e_if_gnt;
      logic       e_d_gnt;
      logic [3:0] e_starve;
      logic       e_if_rv;
      logic       e_d_rv;
   } vec_t;

   vec_t tbl[14];

   // randomized-phase state
   logic          if_pend, d_pend;
   int            m_starve;
   logic          exp_if, exp_d;
   logic [33:0]   e;

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

      for (int i = 0; i < NWORDS; i++) preload(i, 32'h0);

      // Reset state with both requesters pushing a store/fetch.
      drive_if(1'b1, 15'h0);
      drive_d(1'b1, 1'b1, 4'hF, 15'h4, 32'hDEADBEEF);
      #12;
      check("rst_if_gnt", if_gnt, 1'b0);
      check("rst_d_gnt", d_gnt, 1'b0);
      check("rst_wren", mem_wren, 4'h0);
      check("rst_if_rvalid", if_rvalid, 1'b0);
      check("rst_d_rvalid", d_rvalid, 1'b0);
      check("rst_starve", starve_cnt, 4'd0);
      check("rst_state", resp_state, 2'd0);
      drive_if(1'b0, '0);
      drive_d(1'b0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);
      reset = 1'b0;

      // Reset mid-read.
      tick();
      drive_if(1'b1, 15'h10);
      @(negedge clk);
      check("midrd_gnt", if_gnt, 1'b1);
      check("midrd_addr", mem_addr, 32'h4);
      reset = 1'b1;
      #1;
      check("midrd_gnt_in_rst", if_gnt, 1'b0);
      tick();
      check("midrd_rvalid", if_rvalid, 1'b0);
      check("midrd_state", resp_state, 2'd0);
      check("midrd_starve", starve_cnt, 4'd0);
      drive_if(1'b0, '0);
      @(negedge clk);
      reset = 1'b0;

      // Fetch-only stream.
      for (int i = 0; i < 3; i++) preload(i, 32'hA000_0000 + i);
      for (int c = 0; c < 4; c++) begin
         tick();
         drive_if(c < 3, AW'(4 * c));
         @(negedge clk);
         check("fo_gnt", if_gnt, c < 3);
         check("fo_d_gnt", d_gnt, 1'b0);
         check("fo_starve", starve_cnt, 4'd0);
         check("fo_rvalid", if_rvalid, c > 0);
         if (c > 0) check("fo_rdata", if_rdata, 32'hA000_0000 + c - 1);
      end
      drive_if(1'b0, '0);

      // Store then load, read-after-write.
      preload(8, 32'h11223344);
      tick();
      drive_d(1'b1, 1'b1, 4'b0101, 15'h20, 32'hAABBCCDD);
      @(negedge clk);
      check("st_gnt", d_gnt, 1'b1);
      check("st_wren", mem_wren, 4'b0101);
      check("st_addr", mem_addr, 32'h8);
      check("st_wdata", mem_wdata, 32'hAABBCCDD);
      tick();
      drive_d(1'b1, 1'b0, 4'h0, 15'h20, 32'h0);
      @(negedge clk);
      check("ld_gnt", d_gnt, 1'b1);
      check("ld_wren", mem_wren, 4'h0);
      check("st_no_rvalid", d_rvalid, 1'b0);
      tick();
      drive_d(1'b0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);
      check("ld_rvalid", d_rvalid, 1'b1);
      check("ld_rdata", d_rdata, 32'h11BB33DD);
      check("ld_if_rvalid", if_rvalid, 1'b0);

      // Unaligned address maps onto its word.
      tick();
      drive_d(1'b1, 1'b0, 4'h0, 15'h23, 32'h0);
      @(negedge clk);
      check("al_addr", mem_addr, 32'h8);
      tick();
      drive_d(1'b0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);
      check("al_rvalid", d_rvalid, 1'b1);
      check("al_rdata", d_rdata, 32'h11BB33DD);
      check("al_hold_addr", mem_addr, 32'h8);

      // Contention table, including fetch dropping while starved.
      preload(16, 32'hD0D01616);
      preload(17, 32'h1F1F1717);
      for (int i = 0; i < 14; i++) begin
         tick();
         drive_if(tbl[i].if_req, 15'h44);
         drive_d(tbl[i].d_req, 1'b0, 4'h0, 15'h40, 32'h0);
         @(negedge clk);
         check($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_if_gnt);
         check($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].e_d_gnt);
         check($sformatf("tbl%0d_starve", i), starve_cnt, tbl[i].e_starve);
         check($sformatf("tbl%0d_if_rv", i), if_rvalid, tbl[i].e_if_rv);
         check($sformatf("tbl%0d_d_rv", i), d_rvalid, tbl[i].e_d_rv);
         if (tbl[i].e_if_rv) check($sformatf("tbl%0d_if_rdata", i), if_rdata, 32'h1F1F1717);
         if (tbl[i].e_d_rv) check($sformatf("tbl%0d_d_rdata", i), d_rdata, 32'hD0D01616);
         if (tbl[i].e_if_gnt) check($sformatf("tbl%0d_addr", i), mem_addr, 32'd17);
         if (tbl[i].e_d_gnt) check($sformatf("tbl%0d_addr", i), mem_addr, 32'd16);
      end

      // Randomized run against a transaction-level model.
      for (int w = 64; w < 80; w++) preload(w, $urandom);
      if_pend  = 1'b0;
      d_pend   = 1'b0;
      m_starve = 0;
      drive_if(1'b0, '0);
      drive_d(1'b0, 1'b0, 4'h0, '0, '0);
      for (int c = 0; c < 400; c++) begin
         tick();
         if (!if_pend && $urandom_range(0, 3) != 0) begin
            if_pend = 1'b1;
            if_addr = AW'(32'h100 + $urandom_range(0, 63));
         end
         if (!d_pend && $urandom_range(0, 3) != 0) begin
            d_pend  = 1'b1;
            d_we    = $urandom_range(0, 1) == 1;
            d_be    = 4'($urandom_range(0, 15));
            d_addr  = AW'(32'h100 + $urandom_range(0, 63));
            d_wdata = $urandom;
         end
         if_req = if_pend;
         d_req  = d_pend;
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rnd_if_rvalid", if_rvalid, e[33:32] == 2'd1);
            check("rnd_d_rvalid", d_rvalid, e[33:32] == 2'd2);
            check("rnd_rdata", (e[33:32] == 2'd1) ? if_rdata : d_rdata, e[31:0]);
         end else begin
            check("rnd_if_rvalid_idle", if_rvalid, 1'b0);
            check("rnd_d_rvalid_idle", d_rvalid, 1'b0);
         end
         check("rnd_starve", starve_cnt, 32'(m_starve));
         exp_if = if_pend && (!d_pend || m_starve == SMAX);
         exp_d  = d_pend && !exp_if;
         check("rnd_if_gnt", if_gnt, exp_if);
         check("rnd_d_gnt", d_gnt, exp_d);
         check("rnd_wren", mem_wren, (exp_d && d_we) ? d_be : 4'h0);
         if (exp_if) begin
            check("rnd_if_addr", mem_addr, 32'(if_addr >> 2));
            exp_q.push_back({2'd1, gold[if_addr >> 2]});
            if_pend = 1'b0;
         end
         if (exp_d) begin
            check("rnd_d_addr", mem_addr, 32'(d_addr >> 2));
            if (d_we) begin
               for (int b = 0; b < 4; b++)
                  if (d_be[b]) gold[d_addr >> 2][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
               exp_q.push_back({2'd2, gold[d_addr >> 2]});
            end
            d_pend = 1'b0;
         end
         m_starve = (if_pend && !exp_if) ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
